io_port_bank: RTL

Parametrised multi-channel I/O port block replacing the single InPort/OutPort register pair on the Mini SRC datapath. It provides NUM_IN input channels, each a capture register with a valid/ack handshake, and NUM_OUT output channels, each a FIFO with a valid/ready handshake. A memory-mapped-style status word is readable through the IN path. The CPU reaches it via the `IN`/`OUT` instructions: the channel index comes from the instruction, `e_InPort` and `e_OutPort` come from the control unit, and data moves over the bus.

---
 rtl/io_port_bank.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// Multi-channel I/O port bank for the Mini SRC datapath: capture registers with
// valid/ack on the IN side, per-channel FIFOs with valid/ready on the OUT side.
module io_port_bank #(
    parameter int DATA_W    = 32,
    parameter int NUM_IN    = 2,
    parameter int NUM_OUT   = 2,
    parameter int OUT_DEPTH = 4,
    parameter int SEL_W     = 4
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [DATA_W-1:0]         bus_in,
    input  logic                      e_OutPort,
    input  logic                      e_InPort,
    input  logic [SEL_W-1:0]          port_sel,
    output logic [DATA_W-1:0]         in_data,
    output logic                      in_valid,
    input  logic [NUM_IN*DATA_W-1:0]  ext_in_data,
    input  logic [NUM_IN-1:0]         ext_in_strobe,
    output logic [NUM_IN-1:0]         ext_in_ack,
    output logic [NUM_OUT*DATA_W-1:0] ext_out_data,
    output logic [NUM_OUT-1:0]        ext_out_valid,
    input  logic [NUM_OUT-1:0]        ext_out_ready
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic                     status_sel_s;
    logic                     status_rd_s;
    logic [NUM_IN-1:0]        in_sel_s;
    logic [NUM_IN-1:0]        in_valid_s;
    logic [NUM_IN*DATA_W-1:0] in_masked_s;
    logic [NUM_OUT-1:0]       full_s;
    logic [NUM_OUT-1:0]       ovf_s;
    logic [DATA_W-1:0]        status_s;
    logic [DATA_W-1:0]        in_or_s;

    assign status_sel_s = (port_sel == {SEL_W{1'b1}});
    assign status_rd_s  = e_InPort & status_sel_s;

    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_in
            logic [DATA_W-1:0] data_r;
            logic              valid_r;
            logic              ack_r;
            logic              cap_s;
            logic              rd_s;

            // The ack term keeps a slow device from being captured twice.
            assign in_sel_s[i] = (port_sel == SEL_W'(i));
            assign cap_s       = ext_in_strobe[i] & ~valid_r & ~ack_r;
            assign rd_s        = e_InPort & in_sel_s[i];
            assign in_valid_s[i] = valid_r;
            assign ext_in_ack[i] = ack_r;
            assign in_masked_s[i*DATA_W +: DATA_W] = data_r & {DATA_W{in_sel_s[i]}};

            // Capture register, unread flag and one-cycle ack pulse.
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    data_r  <= {DATA_W{1'b0}};
                    valid_r <= 1'b0;
                    ack_r   <= 1'b0;
                end else begin
                    ack_r <= cap_s;
                    if (cap_s) begin
                        data_r  <= ext_in_data[i*DATA_W +: DATA_W];
                        valid_r <= 1'b1;
                    end else if (rd_s) begin
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
            end
        end

        for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
            logic [DATA_W-1:0] mem_r [OUT_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_r;
            logic [PTR_W-1:0]  rd_ptr_r;
            logic [CNT_W-1:0]  count_r;
            logic              ovf_r;
            logic              nonempty_s;
            logic              full_l_s;
            logic              pop_s;
            logic              push_req_s;
            logic              push_s;

            assign nonempty_s = (count_r != {CNT_W{1'b0}});
            assign full_l_s   = (count_r == CNT_W'(OUT_DEPTH));
            assign pop_s      = nonempty_s & ext_out_ready[j];
            assign push_req_s = e_OutPort & (port_sel == SEL_W'(j));
            // A pop in the same cycle frees the slot the push lands in.
            assign push_s     = push_req_s & (~full_l_s | pop_s);

            assign full_s[j]        = full_l_s;
            assign ovf_s[j]         = ovf_r;
            assign ext_out_valid[j] = nonempty_s;
            assign ext_out_data[j*DATA_W +: DATA_W] =
                nonempty_s ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};

            // FIFO storage; contents are never visible while count_r is zero.
            always_ff @(posedge clock) begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= bus_in;
                end
            end

            // Pointers, occupancy and sticky overflow (a new overflow beats read-to-clear).
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    wr_ptr_r <= {PTR_W{1'b0}};
                    rd_ptr_r <= {PTR_W{1'b0}};
                    count_r  <= {CNT_W{1'b0}};
                    ovf_r    <= 1'b0;
                end else begin
                    if (push_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                    end
                    if (pop_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                    end
                    case ({push_s, pop_s})
                        2'b10:   count_r <= count_r + CNT_W'(1);
                        2'b01:   count_r <= count_r - CNT_W'(1);
                        default: count_r <= count_r;
                    endcase
                    ovf_r <= (push_req_s & full_l_s & ~pop_s) | (ovf_r & ~status_rd_s);
                end
            end
        end
    endgenerate

    // OR of the channel words; at most one is unmasked by port_sel.
    always_comb begin
        in_or_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            in_or_s = in_or_s | in_masked_s[i*DATA_W +: DATA_W];
        end
    end

    // Status word: valid bits lowest, then full, then overflow.
    always_comb begin
        status_s = {DATA_W{1'b0}};
        status_s[NUM_IN-1:0]                = in_valid_s;
        status_s[NUM_IN +: NUM_OUT]         = full_s;
        status_s[NUM_IN+NUM_OUT +: NUM_OUT] = ovf_s;
    end

    assign in_data  = status_sel_s ? status_s : in_or_s;
    assign in_valid = |(in_valid_s & in_sel_s);

endmodule
